// File: rtl/mycpu_defs.sv
// Shared encodings for the pipeline hazard logic.
// Covers forwarding mux selects and divider-control FSM states.
package mycpu_defs;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

   // Register 0 is hardwired to zero, so a write to it is never a forwarding source.
   function automatic logic fwd_hit(input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst,
                                    input logic             we);
      return we && (src == dst) && (src != '0);
   endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational bypass selection for the D-stage comparator and the E-stage ALU operands.
module forward_unit
   import mycpu_defs::*;
(
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] rs_e,
   input  logic [4:0] rt_e,
   input  logic [4:0] writereg_m,
   input  logic [4:0] writereg_w,
   input  logic       regwrite_m,
   input  logic       regwrite_w,
   output logic       forwardad,
   output logic       forwardbd,
   output logic [1:0] forwardae,
   output logic [1:0] forwardbe
);

   fwd_sel_e sel_ae, sel_be;

   // M holds the younger result, so it wins over W when both match.
   always_comb begin
      sel_ae = FWD_RF;
      if (fwd_hit(rs_e, writereg_m, regwrite_m))
         sel_ae = FWD_M;
      else if (fwd_hit(rs_e, writereg_w, regwrite_w))
         sel_ae = FWD_W;

      sel_be = FWD_RF;
      if (fwd_hit(rt_e, writereg_m, regwrite_m))
         sel_be = FWD_M;
      else if (fwd_hit(rt_e, writereg_w, regwrite_w))
         sel_be = FWD_W;
   end

   assign forwardae = sel_ae;
   assign forwardbe = sel_be;
   assign forwardad = fwd_hit(rs_d, writereg_m, regwrite_m);
   assign forwardbd = fwd_hit(rt_d, writereg_m, regwrite_m);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: load-use and branch hazards, multicycle divider hold,
// memory waits and precise exception flush (deferred while memory is stalled).
module hazard_ctrl
   import mycpu_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] rs_e,
   input  logic [4:0] rt_e,
   input  logic [4:0] writereg_e,
   input  logic [4:0] writereg_m,
   input  logic [4:0] writereg_w,
   input  logic       regwrite_e,
   input  logic       regwrite_m,
   input  logic       regwrite_w,
   input  logic       memtoreg_e,
   input  logic       memtoreg_m,
   input  logic       branch_d,
   input  logic       div_start_e,
   input  logic       div_ready,
   input  logic       imem_stall,
   input  logic       dmem_stall,
   input  logic       exception_m,
   output logic       stallf,
   output logic       stalld,
   output logic       stalle,
   output logic       stallm,
   output logic       stallw,
   output logic       flushf,
   output logic       flushd,
   output logic       flushe,
   output logic       flushm,
   output logic       flushw,
   output logic       forwardad,
   output logic       forwardbd,
   output logic [1:0] forwardae,
   output logic [1:0] forwardbe,
   output logic       div_go,
   output logic       div_cancel
);

   div_state_e state, state_nx;
   logic       exc_pend, exc_pend_nx;
   logic       mem_stall, exc_fire, lwstall, brstall;

   forward_unit u_forward_unit (
      .rs_d       (rs_d),
      .rt_d       (rt_d),
      .rs_e       (rs_e),
      .rt_e       (rt_e),
      .writereg_m (writereg_m),
      .writereg_w (writereg_w),
      .regwrite_m (regwrite_m),
      .regwrite_w (regwrite_w),
      .forwardad  (forwardad),
      .forwardbd  (forwardbd),
      .forwardae  (forwardae),
      .forwardbe  (forwardbe)
   );

   assign mem_stall = imem_stall | dmem_stall;
   assign exc_fire  = (exception_m | exc_pend) & ~mem_stall;
   assign lwstall   = memtoreg_e & ((rs_d == rt_e) | (rt_d == rt_e));
   assign brstall   = branch_d &
                      ((regwrite_e & ((rs_d == writereg_e) | (rt_d == writereg_e))) |
                       (memtoreg_m & ((rs_d == writereg_m) | (rt_d == writereg_m))));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_IDLE;
         exc_pend <= 1'b0;
      end else begin
         state    <= state_nx;
         exc_pend <= exc_pend_nx;
      end
   end

   // NOTE: every output and next-state variable gets a default first so no path infers a latch.
   always_comb begin
      state_nx    = state;
      exc_pend_nx = exc_pend;
      stallf      = 1'b0;
      stalld      = 1'b0;
      stalle      = 1'b0;
      stallm      = 1'b0;
      stallw      = 1'b0;
      flushf      = 1'b0;
      flushd      = 1'b0;
      flushe      = 1'b0;
      flushm      = 1'b0;
      flushw      = 1'b0;
      div_go      = 1'b0;
      div_cancel  = 1'b0;

      if (rst) begin
         {flushf, flushd, flushe, flushm, flushw} = 5'b11111;
      end else if (exc_fire) begin
         {flushf, flushd, flushe, flushm, flushw} = 5'b11111;
         div_cancel  = (state == DIV_BUSY);
         state_nx    = DIV_IDLE;
         exc_pend_nx = 1'b0;
      end else if (mem_stall) begin
         // Freeze everything; remember an exception so it is taken once memory releases.
         {stallf, stalld, stalle, stallm, stallw} = 5'b11111;
         if (exception_m)
            exc_pend_nx = 1'b1;
      end else if (state == DIV_BUSY && !div_ready) begin
         {stallf, stalld, stalle, flushm} = 4'b1111;
      end else begin
         if (state == DIV_BUSY) begin
            state_nx = DIV_IDLE;
         end else if (div_start_e) begin
            div_go   = 1'b1;
            state_nx = DIV_BUSY;
         end
         if (lwstall || brstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            flushe = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multicycle sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
   logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
   logic       branch_d, div_start_e, div_ready, imem_stall, dmem_stall, exception_m;
   logic       stallf, stalld, stalle, stallm, stallw;
   logic       flushf, flushd, flushe, flushm, flushw;
   logic       forwardad, forwardbd, div_go, div_cancel;
   logic [1:0] forwardae, forwardbe;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
      .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
      .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
      .branch_d(branch_d), .div_start_e(div_start_e), .div_ready(div_ready),
      .imem_stall(imem_stall), .dmem_stall(dmem_stall), .exception_m(exception_m),
      .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm), .stallw(stallw),
      .flushf(flushf), .flushd(flushd), .flushe(flushe), .flushm(flushm), .flushw(flushw),
      .forwardad(forwardad), .forwardbd(forwardbd),
      .forwardae(forwardae), .forwardbe(forwardbe),
      .div_go(div_go), .div_cancel(div_cancel)
   );

   // Observed outputs packed: stalls f..w, flushes f..w, fad, fbd, fae, fbe, div_go, div_cancel.
   logic [17:0] obs;
   assign obs = {stallf, stalld, stalle, stallm, stallw,
                 flushf, flushd, flushe, flushm, flushw,
                 forwardad, forwardbd, forwardae, forwardbe, div_go, div_cancel};

   localparam logic [17:0] S_F = 18'd1 << 17, S_D = 18'd1 << 16, S_E = 18'd1 << 15;
   localparam logic [17:0] S_M = 18'd1 << 14, S_W = 18'd1 << 13;
   localparam logic [17:0] F_F = 18'd1 << 12, F_D = 18'd1 << 11, F_E = 18'd1 << 10;
   localparam logic [17:0] F_M = 18'd1 << 9,  F_W = 18'd1 << 8;
   localparam logic [17:0] GO  = 18'd1 << 1,  CAN = 18'd1;
   localparam logic [17:0] STALLS  = S_F | S_D | S_E | S_M | S_W;
   localparam logic [17:0] FLUSHES = F_F | F_D | F_E | F_M | F_W;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk(input string name, input logic [17:0] mask, input logic [17:0] exp);
      check(name, obs & mask, exp & mask);
   endtask

   // Behavioural model: divider busy flag and pending-exception flag.
   bit          m_busy = 1'b0, m_pend = 1'b0;
   bit          nx_busy, nx_pend;
   logic [17:0] m_exp;

   function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
      if (src != 0 && src == writereg_m && regwrite_m) return 2'b10;
      if (src != 0 && src == writereg_w && regwrite_w) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_eval();
      bit ms, exc, divhold, hz, lw, br, run;
      ms      = imem_stall | dmem_stall;
      exc     = !rst && !ms && (exception_m || m_pend);
      run     = !rst && !exc && !ms;
      divhold = run && m_busy && !div_ready;
      lw      = memtoreg_e && (rs_d == rt_e || rt_d == rt_e);
      br      = branch_d &&
                ((regwrite_e && (rs_d == writereg_e || rt_d == writereg_e)) ||
                 (memtoreg_m && (rs_d == writereg_m || rt_d == writereg_m)));
      hz      = run && !divhold && (lw || br);
      m_exp = {
         (ms || divhold || hz) && !rst && !exc,
         (ms || divhold || hz) && !rst && !exc,
         (ms || divhold) && !rst && !exc,
         ms && !rst && !exc,
         ms && !rst && !exc,
         rst || exc, rst || exc, rst || exc || hz, rst || exc || divhold, rst || exc,
         (rs_d != 0 && rs_d == writereg_m && regwrite_m),
         (rt_d != 0 && rt_d == writereg_m && regwrite_m),
         ref_fwd_e(rs_e), ref_fwd_e(rt_e),
         run && !m_busy && div_start_e,
         !rst && exc && m_busy};
      if (rst || exc)   begin nx_busy = 0;           nx_pend = 0; end
      else if (ms)      begin nx_busy = m_busy;      nx_pend = m_pend | exception_m; end
      else if (m_busy)  begin nx_busy = !div_ready;  nx_pend = m_pend; end
      else              begin nx_busy = div_start_e; nx_pend = m_pend; end
   endtask

   task automatic sample();
      @(negedge clk);
      model_eval();
      check("model", obs, m_exp);
   endtask

   task automatic advance();
      @(posedge clk);
      m_busy = nx_busy;
      m_pend = nx_pend;
      #1;
   endtask

   task automatic clear_inputs();
      {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
      {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
      {branch_d, div_start_e, div_ready, imem_stall, dmem_stall, exception_m} = '0;
   endtask

   typedef struct {
      logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
      logic       rwe, rwm, rww, mte, mtm, br;
      logic [1:0] fae, fbe;
      logic       fad, fbd, hz;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{0, 0, 3, 0,  0, 3, 3,   0, 1, 1, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0,  0, 0, 0,   0, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0};
      tbl[2]  = '{5, 0, 0, 5,  0, 0, 0,   0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 1};
      tbl[3]  = '{0, 0, 0, 7,  0, 7, 7,   0, 0, 1, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0};
      tbl[4]  = '{0, 0, 4, 0,  0, 4, 4,   0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0};
      tbl[5]  = '{9, 9, 0, 0,  0, 9, 0,   0, 1, 0, 0, 0, 0,  2'b00, 2'b00, 1, 1, 0};
      tbl[6]  = '{1, 6, 0, 6,  0, 0, 0,   0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 1};
      tbl[7]  = '{8, 0, 0, 0,  8, 0, 0,   1, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 1};
      tbl[8]  = '{0, 10, 0, 0, 0, 10, 0,  0, 1, 0, 0, 1, 1,  2'b00, 2'b00, 0, 1, 1};
      tbl[9]  = '{11, 0, 0, 0, 0, 11, 0,  0, 1, 0, 0, 0, 1,  2'b00, 2'b00, 1, 0, 0};
      tbl[10] = '{13, 14, 0, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0};

      clear_inputs();
      rst = 1'b1;
      sample();
      chk("reset_outputs", STALLS | FLUSHES | GO | CAN, FLUSHES);
      advance();
      sample();
      chk("reset_hold", STALLS | FLUSHES | GO | CAN, FLUSHES);
      advance();
      rst = 1'b0;

      // Combinational forwarding and load/branch hazards from an idle pipeline.
      for (int i = 0; i < 11; i++) begin
         rs_d = tbl[i].rs_d; rt_d = tbl[i].rt_d; rs_e = tbl[i].rs_e; rt_e = tbl[i].rt_e;
         writereg_e = tbl[i].wr_e; writereg_m = tbl[i].wr_m; writereg_w = tbl[i].wr_w;
         regwrite_e = tbl[i].rwe; regwrite_m = tbl[i].rwm; regwrite_w = tbl[i].rww;
         memtoreg_e = tbl[i].mte; memtoreg_m = tbl[i].mtm; branch_d = tbl[i].br;
         sample();
         check($sformatf("vec%0d", i), obs,
               {tbl[i].hz, tbl[i].hz, 3'b000, 2'b00, tbl[i].hz, 2'b00,
                tbl[i].fad, tbl[i].fbd, tbl[i].fae, tbl[i].fbe, 2'b00});
         advance();
      end

      // Divider: one go pulse, eight held cycles, release on ready, back to idle.
      clear_inputs();
      div_start_e = 1'b1;
      sample();
      chk("div_go_pulse", GO | S_E, GO);
      advance();
      for (int i = 0; i < 8; i++) begin
         div_start_e = (i == 2);
         sample();
         chk("div_busy_hold", S_F | S_D | S_E | S_M | F_M | GO, S_F | S_D | S_E | F_M);
         advance();
      end
      div_start_e = 1'b0;
      div_ready   = 1'b1;
      sample();
      chk("div_ready_release", S_F | S_D | S_E | F_M, '0);
      advance();
      div_ready   = 1'b0;
      div_start_e = 1'b1;
      sample();
      chk("div_idle_after", GO | S_E, GO);
      advance();
      div_start_e = 1'b0;
      div_ready   = 1'b1;
      sample();
      advance();

      // Exception arriving under a data-memory wait is deferred, then flushed once.
      clear_inputs();
      dmem_stall  = 1'b1;
      exception_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("memstall_noflush", STALLS | FLUSHES, STALLS);
         advance();
      end
      dmem_stall  = 1'b0;
      exception_m = 1'b0;
      sample();
      chk("pend_flush", STALLS | FLUSHES, FLUSHES);
      advance();
      sample();
      chk("pend_cleared", FLUSHES, '0);
      advance();

      // Exception while dividing cancels the divider.
      div_start_e = 1'b1;
      sample();
      advance();
      div_start_e = 1'b0;
      sample();
      chk("busy_before_exc", S_E, S_E);
      advance();
      exception_m = 1'b1;
      sample();
      chk("exc_cancel", STALLS | FLUSHES | CAN | GO, FLUSHES | CAN);
      advance();
      exception_m = 1'b0;
      sample();
      chk("exc_then_idle", S_E | CAN, '0);
      advance();

      // Reset while dividing.
      div_start_e = 1'b1;
      sample();
      advance();
      div_start_e = 1'b0;
      sample();
      advance();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("rst_in_busy", STALLS | FLUSHES | GO | CAN, FLUSHES);
         advance();
      end
      rst = 1'b0;
      sample();
      chk("rst_then_idle", S_E, '0);
      advance();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rs_d = 5'($urandom_range(0, 3));       rt_d = 5'($urandom_range(0, 3));
         rs_e = 5'($urandom_range(0, 3));       rt_e = 5'($urandom_range(0, 3));
         writereg_e = 5'($urandom_range(0, 3)); writereg_m = 5'($urandom_range(0, 3));
         writereg_w = 5'($urandom_range(0, 3));
         regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
         regwrite_w = 1'($urandom_range(0, 1)); memtoreg_e = ($urandom_range(0, 3) == 0);
         memtoreg_m = ($urandom_range(0, 3) == 0);
         branch_d    = ($urandom_range(0, 3) == 0);
         div_start_e = ($urandom_range(0, 5) == 0);
         div_ready   = ($urandom_range(0, 3) == 0);
         imem_stall  = ($urandom_range(0, 9) == 0);
         dmem_stall  = ($urandom_range(0, 9) == 0);
         exception_m = ($urandom_range(0, 24) == 0);
         rst         = ($urandom_range(0, 99) == 0);
         sample();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
